// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Next-PC / PC-enable controller for the fetch stage. Arbitrates
//             sequential fetch, branch, jump, stall, interrupt entry and eret.
//             Owns the EPC register and the handler-mode (EXL) state.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PcAddr,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        JumpTaken,
  input  logic [31:0] JumpTarget,
  input  logic        IntReq,
  input  logic        VictimValid,
  input  logic [31:0] VictimPC,
  input  logic        VictimInDS,
  input  logic        EretReq,
  output logic [31:0] NextPC,
  output logic        PcEn,
  output logic        Flush,
  output logic        IntAck,
  output logic [31:0] EPC,
  output logic        Exl
);

  localparam logic [31:0] c_INSN_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_INT_WAIT  = 2'd1,
    S_HANDLER   = 2'd2,
    S_ERET_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_epc;
  logic        w_epc_load;
  logic [31:0] w_epc_value;
  logic        w_enter;
  logic [31:0] w_fetch_pc;
  logic        w_fetch_en;

  // Entry only when the M-stage victim is a real instruction and fetch may move.
  assign w_enter = IntReq & VictimValid & ~Stall;

  // A victim in a delay slot must restart at its branch so the branch re-executes.
  assign w_epc_value = VictimInDS ? (VictimPC - c_INSN_BYTES) : VictimPC;

  // Normal fetch: stall holds, else jump, else branch, else sequential.
  always_comb begin
    w_fetch_pc = PcAddr + c_INSN_BYTES;
    w_fetch_en = 1'b1;
    if (Stall) begin
      w_fetch_pc = PcAddr;
      w_fetch_en = 1'b0;
    end else if (JumpTaken) begin
      w_fetch_pc = JumpTarget;
    end else if (BranchTaken) begin
      w_fetch_pc = BranchTarget;
    end
  end

  // Next-state and redirect decision; reset overrides every source.
  always_comb begin
    w_state_next = r_state;
    NextPC       = w_fetch_pc;
    PcEn         = w_fetch_en;
    Flush        = 1'b0;
    IntAck       = 1'b0;
    w_epc_load   = 1'b0;

    case (r_state)
      S_RUN, S_INT_WAIT: begin
        if (w_enter) begin
          NextPC       = HANDLER_PC;
          PcEn         = 1'b1;
          Flush        = 1'b1;
          IntAck       = 1'b1;
          w_epc_load   = 1'b1;
          w_state_next = S_HANDLER;
        end else if (IntReq) begin
          w_state_next = S_INT_WAIT;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_HANDLER: begin
        if (EretReq && !Stall) begin
          NextPC       = r_epc;
          PcEn         = 1'b1;
          Flush        = 1'b1;
          w_state_next = S_ERET_HOLD;
        end
      end
      S_ERET_HOLD: begin
        // One plain fetch cycle so the returned-to instruction enters the pipe.
        w_state_next = S_RUN;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase

    if (!Reset) begin
      NextPC       = RESET_PC;
      PcEn         = 1'b1;
      Flush        = 1'b1;
      IntAck       = 1'b0;
      w_epc_load   = 1'b0;
      w_state_next = S_RUN;
    end
  end

  // State register and EPC capture on handler entry.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_RUN;
      r_epc   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_epc_load) begin
        r_epc <= w_epc_value;
      end
    end
  end

  assign EPC = r_epc;
  assign Exl = (r_state == S_HANDLER) || (r_state == S_ERET_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic [31:0] PcAddr;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic        IntReq;
  logic        VictimValid;
  logic [31:0] VictimPC;
  logic        VictimInDS;
  logic        EretReq;
  logic [31:0] NextPC;
  logic        PcEn;
  logic        Flush;
  logic        IntAck;
  logic [31:0] EPC;
  logic        Exl;

  int r_checks;
  int r_errors;

  pc_sequencer #(
    .RESET_PC   (32'h0000_3000),
    .HANDLER_PC (32'h0000_4180)
  ) u_dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PcAddr       (PcAddr),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .JumpTaken    (JumpTaken),
    .JumpTarget   (JumpTarget),
    .IntReq       (IntReq),
    .VictimValid  (VictimValid),
    .VictimPC     (VictimPC),
    .VictimInDS   (VictimInDS),
    .EretReq      (EretReq),
    .NextPC       (NextPC),
    .PcEn         (PcEn),
    .Flush        (Flush),
    .IntAck       (IntAck),
    .EPC          (EPC),
    .Exl          (Exl)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs then change away from the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    r_checks = 0;
    r_errors = 0;
    Reset = 1'b0; PcAddr = 32'h0; Stall = 1'b0;
    BranchTaken = 1'b0; BranchTarget = 32'h0;
    JumpTaken = 1'b0; JumpTarget = 32'h0;
    IntReq = 1'b0; VictimValid = 1'b0; VictimPC = 32'h0;
    VictimInDS = 1'b0; EretReq = 1'b0;

    // ---------------- reset and sequential fetch ----------------
    tick();
    check("rst_nextpc", NextPC, 32'h3000);
    check("rst_pcen",   {31'd0, PcEn}, 32'd1);
    check("rst_flush",  {31'd0, Flush}, 32'd1);
    check("rst_intack", {31'd0, IntAck}, 32'd0);
    check("rst_exl",    {31'd0, Exl}, 32'd0);
    check("rst_epc",    EPC, 32'h0);
    tick();
    check("rst2_nextpc", NextPC, 32'h3000);
    Reset = 1'b1; PcAddr = 32'h3000; settle();
    check("seq0_nextpc", NextPC, 32'h3004);
    check("seq0_pcen",   {31'd0, PcEn}, 32'd1);
    check("seq0_flush",  {31'd0, Flush}, 32'd0);
    tick();
    PcAddr = 32'h3004; settle();
    check("seq1_nextpc", NextPC, 32'h3008);
    tick();

    // ---------------- redirect priority ----------------
    PcAddr = 32'h3010;
    JumpTaken = 1'b1; JumpTarget = 32'h3100;
    BranchTaken = 1'b1; BranchTarget = 32'h3200; settle();
    check("jmp_over_br", NextPC, 32'h3100);
    JumpTaken = 1'b0; settle();
    check("branch_only", NextPC, 32'h3200);
    JumpTaken = 1'b1; Stall = 1'b1; settle();
    check("stall_pcen",   {31'd0, PcEn}, 32'd0);
    check("stall_nextpc", NextPC, 32'h3010);
    tick();
    JumpTaken = 1'b0; BranchTaken = 1'b0; Stall = 1'b0;
    PcAddr = 32'hFFFF_FFFC; settle();
    check("seq_wrap", NextPC, 32'h0);
    tick();

    // ---------------- interrupt through bubbles ----------------
    PcAddr = 32'h3020; IntReq = 1'b1; VictimValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bubble_noack", {31'd0, IntAck}, 32'd0);
      check("bubble_fetch", NextPC, 32'h3024);
      tick();
    end
    VictimValid = 1'b1; VictimPC = 32'h3020; Stall = 1'b1; settle();
    check("wait_stall_noack", {31'd0, IntAck}, 32'd0);
    check("wait_stall_pcen",  {31'd0, PcEn}, 32'd0);
    tick();
    Stall = 1'b0; settle();
    check("entry_ack",    {31'd0, IntAck}, 32'd1);
    check("entry_flush",  {31'd0, Flush}, 32'd1);
    check("entry_nextpc", NextPC, 32'h4180);
    tick();
    PcAddr = 32'h4180; settle();
    check("hdl_epc",   EPC, 32'h3020);
    check("hdl_exl",   {31'd0, Exl}, 32'd1);
    check("hdl_noack", {31'd0, IntAck}, 32'd0);
    check("hdl_fetch", NextPC, 32'h4184);
    tick();

    // ---------------- eret and holdoff ----------------
    EretReq = 1'b1; Stall = 1'b1; settle();
    check("eret_stall_pcen",  {31'd0, PcEn}, 32'd0);
    check("eret_stall_flush", {31'd0, Flush}, 32'd0);
    tick();
    Stall = 1'b0; settle();
    check("eret_nextpc", NextPC, 32'h3020);
    check("eret_flush",  {31'd0, Flush}, 32'd1);
    tick();
    EretReq = 1'b0; PcAddr = 32'h3020; settle();
    check("hold_noack", {31'd0, IntAck}, 32'd0);
    check("hold_exl",   {31'd0, Exl}, 32'd1);
    check("hold_fetch", NextPC, 32'h3024);
    tick();

    // ---------------- re-entry with delay-slot victim ----------------
    VictimInDS = 1'b1; VictimPC = 32'h3040; settle();
    check("reentry_ack", {31'd0, IntAck}, 32'd1);
    check("reentry_exl", {31'd0, Exl}, 32'd0);
    tick();
    VictimInDS = 1'b0; settle();
    check("ds_epc", EPC, 32'h303C);
    check("ds_exl", {31'd0, Exl}, 32'd1);

    // ---------------- reset while in handler ----------------
    Reset = 1'b0; settle();
    check("hrst_nextpc", NextPC, 32'h3000);
    check("hrst_intack", {31'd0, IntAck}, 32'd0);
    tick();
    check("hrst_exl", {31'd0, Exl}, 32'd0);
    check("hrst_epc", EPC, 32'h0);
    Reset = 1'b1;

    // ---------------- withdrawn request ----------------
    IntReq = 1'b1; VictimValid = 1'b0; PcAddr = 32'h3050; settle();
    check("wd_noack0", {31'd0, IntAck}, 32'd0);
    tick();
    IntReq = 1'b0; settle();
    check("wd_noack1", {31'd0, IntAck}, 32'd0);
    tick();
    EretReq = 1'b1; settle();
    check("eret_in_run_fetch", NextPC, 32'h3054);
    check("eret_in_run_flush", {31'd0, Flush}, 32'd0);
    check("wd_run_exl", {31'd0, Exl}, 32'd0);
    tick();
    EretReq = 1'b0;

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
